// File: rtl/ecc_serial_rx.sv
// ecc_serial_rx: serial Hamming(12,8) frame receiver with SEC (or SECDED when ECC_SECDED_EN is defined), output FIFO and saturating error counters; ports clk, rst, bit_valid, serial_in, out_data, out_corrected, out_uncorrectable, out_valid, out_ready, framing_err, overflow, corr_count, uncorr_count
module ecc_serial_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_valid,
  input  logic                 serial_in,
  output logic [7:0]           out_data,
  output logic                 out_corrected,
  output logic                 out_uncorrectable,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 framing_err,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] corr_count,
  output logic [CNT_WIDTH-1:0] uncorr_count
);
`ifdef ECC_SECDED_EN
  localparam int N = 13;
`else
  localparam int N = 12;
`endif
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
  state_t state, state_nx;
  logic [3:0] bit_cnt;
  logic [N-1:0] shreg;
  logic shift_en, frame_ok, frame_bad, rx_vld, dec_vld;
  logic [3:0] syn;
  logic [11:0] fixed;
  logic corr, unc;
  logic [7:0] dec_data;
  logic [9:0] dec_word;
  logic [9:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic empty, full, push, pop;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = !bit_valid ? state :
               state == IDLE ? (serial_in ? IDLE : DATA) :
               state == DATA ? (bit_cnt == 4'(N - 1) ? STOP : DATA) : IDLE;
  always_comb begin
    shift_en  = bit_valid && state == DATA;
    frame_ok  = bit_valid && state == STOP && serial_in;
    frame_bad = bit_valid && state == STOP && !serial_in;
  end
  // The shift register holds the codeword untouched from the stop-bit edge
  // until the next frame's first data bit, so decode reads it directly.
  always_ff @(posedge clk) begin
    if (shift_en) shreg <= {serial_in, shreg[N-1:1]};
    if (rst) begin
      bit_cnt     <= '0;
      rx_vld      <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      bit_cnt     <= state == IDLE ? 4'd0 : bit_cnt + 4'(shift_en);
      rx_vld      <= frame_ok;
      framing_err <= frame_bad;
    end
  end
  always_comb begin
    syn = '0;
    for (int i = 0; i < 12; i++) if (shreg[i]) syn ^= 4'(i + 1);
`ifdef ECC_SECDED_EN
    corr = ^shreg;
    unc  = syn != 4'd0 && !(^shreg);
`else
    corr = syn != 4'd0 && syn <= 4'd12;
    unc  = syn > 4'd12;
`endif
    fixed    = shreg[11:0] ^ ((corr && syn != 4'd0 && syn <= 4'd12) ? 12'd1 << (syn - 4'd1) : 12'd0);
    dec_data = {fixed[11:8], fixed[6:4], fixed[2]};
  end
  always_ff @(posedge clk) begin
    if (rx_vld) dec_word <= {unc, corr, dec_data};
    if (rst) begin
      dec_vld      <= 1'b0;
      corr_count   <= '0;
      uncorr_count <= '0;
    end else begin
      dec_vld <= rx_vld;
      if (rx_vld && corr && !(&corr_count)) corr_count <= corr_count + 1'b1;
      if (rx_vld && unc && !(&uncorr_count)) uncorr_count <= uncorr_count + 1'b1;
    end
  end
  always_comb begin
    empty = wr_ptr == rd_ptr;
    full  = wr_ptr[AW] != rd_ptr[AW] && wr_ptr[AW-1:0] == rd_ptr[AW-1:0];
    pop   = !empty && out_ready;
    push  = dec_vld && (!full || pop);
    out_valid = !empty;
    {out_uncorrectable, out_corrected, out_data} = empty ? 10'd0 : mem[rd_ptr[AW-1:0]];
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= dec_word;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + (AW + 1)'(push);
      rd_ptr   <= rd_ptr + (AW + 1)'(pop);
      overflow <= dec_vld && full && !pop;
    end
endmodule

// File: tb/tb_ecc_serial_rx.sv
// tb_ecc_serial_rx: randomized self-checking bench for ecc_serial_rx against a behavioural Hamming model
module tb_ecc_serial_rx;
  logic clk = 1'b0;
  logic rst, bit_valid, serial_in, out_ready;
  logic [7:0] out_data;
  logic out_corrected, out_uncorrectable, out_valid, framing_err, overflow;
  logic [15:0] corr_count, uncorr_count;
  int tests = 0;
  int fails = 0;
  int exp_corr = 0;
  int exp_unc = 0;
  logic [9:0] q[$];
  localparam int DPOS[8] = '{3, 5, 6, 7, 9, 10, 11, 12};

  ecc_serial_rx dut (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .serial_in(serial_in),
    .out_data(out_data), .out_corrected(out_corrected), .out_uncorrectable(out_uncorrectable),
    .out_valid(out_valid), .out_ready(out_ready), .framing_err(framing_err), .overflow(overflow),
    .corr_count(corr_count), .uncorr_count(uncorr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] encode(input logic [7:0] d);
    logic [11:0] cw = '0;
    int s = 0;
    for (int i = 0; i < 8; i++) cw[DPOS[i]-1] = d[i];
    for (int p = 1; p <= 12; p++) if (cw[p-1]) s ^= p;
    cw[0] = s[0];
    cw[1] = s[1];
    cw[3] = s[2];
    cw[7] = s[3];
    return cw;
  endfunction

  function automatic logic [9:0] model(input logic [11:0] cw);
    int syn = 0;
    logic [11:0] f = cw;
    logic c = 1'b0;
    logic u = 1'b0;
    logic [7:0] d;
    for (int p = 1; p <= 12; p++) if (cw[p-1]) syn ^= p;
    if (syn >= 1 && syn <= 12) begin
      f[syn-1] = ~f[syn-1];
      c = 1'b1;
    end else if (syn > 12) u = 1'b1;
    for (int i = 0; i < 8; i++) d[i] = f[DPOS[i]-1];
    return {u, c, d};
  endfunction

  function automatic logic [11:0] make_cw(input logic [7:0] d, input int nerr);
    logic [11:0] cw = encode(d);
    int a = $urandom_range(0, 11);
    if (nerr > 0) cw[a] = ~cw[a];
    if (nerr > 1) begin
      a = (a + $urandom_range(1, 11)) % 12;
      cw[a] = ~cw[a];
    end
    return cw;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    if ($urandom_range(0, 3) == 0)
      repeat ($urandom_range(1, 3)) begin
        bit_valid = 1'b0;
        serial_in = 1'($urandom);
        tick();
      end
    bit_valid = 1'b1;
    serial_in = b;
    tick();
    bit_valid = 1'b0;
    serial_in = 1'b1;
  endtask

  task automatic send_frame(input logic [11:0] cw, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 12; i++) send_bit(cw[i]);
    send_bit(stop);
  endtask

  task automatic expect_word(input logic [11:0] cw);
    logic [9:0] m = model(cw);
    q.push_back(m);
    exp_corr += int'(m[8]);
    exp_unc  += int'(m[9]);
  endtask

  task automatic pop_head();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if ({out_valid, framing_err, overflow, out_corrected, out_uncorrectable} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 00000", {out_valid, framing_err, overflow, out_corrected, out_uncorrectable});
    end
    tests++;
    if (out_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_data: got %h expected 00", out_data);
    end
    tests++;
    if ({corr_count, uncorr_count} !== 32'd0) begin
      fails++;
      $display("FAIL reset_counts: got %0d/%0d expected 0/0", corr_count, uncorr_count);
    end
  endtask

  task automatic test_clean();
    send_frame(12'hA58, 1'b1);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL latency_0: got %b expected 0", out_valid);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL latency_1: got %b expected 0", out_valid);
    end
    tick();
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL latency_2: got %b expected 1", out_valid);
    end
    tests++;
    if ({out_uncorrectable, out_corrected, out_data} !== 10'h0AA) begin
      fails++;
      $display("FAIL clean_word: got %h expected 0aa", {out_uncorrectable, out_corrected, out_data});
    end
    pop_head();
  endtask

  task automatic test_single();
    send_frame(12'hA78, 1'b1);
    repeat (2) tick();
    tests++;
    if ({out_valid, out_uncorrectable, out_corrected, out_data} !== {3'b101, 8'hAA}) begin
      fails++;
      $display("FAIL single_word: got %h expected %h", {out_valid, out_uncorrectable, out_corrected, out_data}, {3'b101, 8'hAA});
    end
    tests++;
    if (corr_count !== 16'd1) begin
      fails++;
      $display("FAIL single_count: got %0d expected 1", corr_count);
    end
    pop_head();
  endtask

  task automatic test_double();
    send_frame(12'h259, 1'b1);
    repeat (2) tick();
    tests++;
    if ({out_valid, out_uncorrectable, out_corrected, out_data} !== {3'b110, 8'h2A}) begin
      fails++;
      $display("FAIL double_word: got %h expected %h", {out_valid, out_uncorrectable, out_corrected, out_data}, {3'b110, 8'h2A});
    end
    tests++;
    if ({corr_count, uncorr_count} !== {16'd1, 16'd1}) begin
      fails++;
      $display("FAIL double_count: got %0d/%0d expected 1/1", corr_count, uncorr_count);
    end
    pop_head();
    exp_corr = 1;
    exp_unc = 1;
  endtask

  task automatic test_framing();
    logic [11:0] cw = encode(8'($urandom));
    send_frame(encode(8'h5C), 1'b0);
    tests++;
    if (framing_err !== 1'b1) begin
      fails++;
      $display("FAIL framing_pulse: got %b expected 1", framing_err);
    end
    tick();
    tests++;
    if (framing_err !== 1'b0) begin
      fails++;
      $display("FAIL framing_end: got %b expected 0", framing_err);
    end
    repeat (3) tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL framing_nowrite: got %b expected 0", out_valid);
    end
    expect_word(cw);
    send_frame(cw, 1'b1);
    repeat (2) tick();
    tests++;
    if ({out_valid, out_uncorrectable, out_corrected, out_data} !== {1'b1, q[0]}) begin
      fails++;
      $display("FAIL framing_next: got %h expected %h", {out_valid, out_uncorrectable, out_corrected, out_data}, {1'b1, q[0]});
    end
    void'(q.pop_front());
    pop_head();
  endtask

  task automatic test_overflow();
    logic [11:0] cw;
    for (int i = 0; i < 5; i++) begin
      cw = make_cw(8'($urandom), $urandom_range(0, 1));
      expect_word(cw);
      send_frame(cw, 1'b1);
      tests++;
      if (overflow !== 1'b0) begin
        fails++;
        $display("FAIL overflow_early%0d: got %b expected 0", i, overflow);
      end
    end
    void'(q.pop_back());
    repeat (2) tick();
    tests++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_pulse: got %b expected 1", overflow);
    end
    tick();
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL overflow_end: got %b expected 0", overflow);
    end
    tests++;
    if ({corr_count, uncorr_count} !== {16'(exp_corr), 16'(exp_unc)}) begin
      fails++;
      $display("FAIL overflow_counts: got %0d/%0d expected %0d/%0d", corr_count, uncorr_count, exp_corr, exp_unc);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({out_valid, out_uncorrectable, out_corrected, out_data} !== {1'b1, q[0]}) begin
        fails++;
        $display("FAIL drain%0d: got %h expected %h", i, {out_valid, out_uncorrectable, out_corrected, out_data}, {1'b1, q[0]});
      end
      void'(q.pop_front());
      pop_head();
    end
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL drain_empty: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] cw = encode(8'($urandom));
    send_frame(encode(8'h33), 1'b1);
    tick();
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    exp_corr = 0;
    exp_unc = 0;
    tests++;
    if ({out_valid, framing_err, overflow, out_data} !== 11'd0) begin
      fails++;
      $display("FAIL midreset_state: got %h expected 000", {out_valid, framing_err, overflow, out_data});
    end
    tests++;
    if ({corr_count, uncorr_count} !== 32'd0) begin
      fails++;
      $display("FAIL midreset_counts: got %0d/%0d expected 0/0", corr_count, uncorr_count);
    end
    expect_word(cw);
    send_frame(cw, 1'b1);
    repeat (2) tick();
    tests++;
    if ({out_valid, out_uncorrectable, out_corrected, out_data} !== {1'b1, q[0]}) begin
      fails++;
      $display("FAIL midreset_next: got %h expected %h", {out_valid, out_uncorrectable, out_corrected, out_data}, {1'b1, q[0]});
    end
    void'(q.pop_front());
    pop_head();
  endtask

  task automatic test_random();
    logic [11:0] cw;
    for (int i = 0; i < 30; i++) begin
      cw = make_cw(8'($urandom), $urandom_range(0, 2));
      expect_word(cw);
      send_frame(cw, 1'b1);
      repeat (2) tick();
      tests++;
      if ({out_valid, out_uncorrectable, out_corrected, out_data} !== {1'b1, q[0]}) begin
        fails++;
        $display("FAIL random%0d cw=%h: got %h expected %h", i, cw, {out_valid, out_uncorrectable, out_corrected, out_data}, {1'b1, q[0]});
      end
      tests++;
      if ({corr_count, uncorr_count} !== {16'(exp_corr), 16'(exp_unc)}) begin
        fails++;
        $display("FAIL random_counts%0d: got %0d/%0d expected %0d/%0d", i, corr_count, uncorr_count, exp_corr, exp_unc);
      end
      void'(q.pop_front());
      pop_head();
    end
  endtask

  initial begin
    rst = 1'b1;
    bit_valid = 1'b0;
    serial_in = 1'b1;
    out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_framing();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
